// File: rtl/blowfish128_round_ctrl.sv
// Blowfish-128 round sequencer: drives the shared F-function through the
// 16-round Feistel schedule (encrypt or decrypt), fetches P-array subkeys
// through a combinational read port and returns the result on valid/ready.
module blowfish128_round_ctrl #(
  parameter int unsigned NROUNDS    = 16,
  parameter int unsigned FF_TIMEOUT = 64
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic         decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         err,
  output logic [4:0]   p_addr,
  input  logic [63:0]  p_data,
  output logic         ff_enable,
  output logic [63:0]  ff_x,
  input  logic [63:0]  ff_y,
  input  logic         ff_valid
);

  localparam int unsigned PAW = 5;
  localparam int unsigned RW  = 5;
  localparam int unsigned TW  = $clog2(FF_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_XOR,
    S_FF_RUN,
    S_FF_DONE,
    S_FIN_A,
    S_FIN_B,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [63:0]      r_l;
  logic [63:0]      r_r;
  logic [63:0]      r_fy;
  logic [RW-1:0]    r_round;
  logic [TW-1:0]    r_tmr;
  logic             r_dec;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_err;
  logic             r_ff_enable;
  logic [PAW-1:0]   r_p_addr;
  logic [RW-1:0]    w_round_nx;

  // Subkey index for a schedule step; decrypt walks the P-array backwards.
  function automatic logic [PAW-1:0] kidx(input logic dec, input logic [RW-1:0] idx);
    kidx = dec ? PAW'(NROUNDS + 32'd1 - 32'(idx)) : PAW'(idx);
  endfunction

  // Next schedule step; p_addr is pre-loaded with its subkey index so the
  // combinational P read is ready in the cycle that consumes it.
  assign w_round_nx = r_round + RW'(1);

  // Round sequencer with all outputs registered.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state     <= S_IDLE;
      r_l         <= '0;
      r_r         <= '0;
      r_fy        <= '0;
      r_round     <= '0;
      r_tmr       <= '0;
      r_dec       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ff_enable <= 1'b0;
      r_p_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_l        <= in_block[127:64];
            r_r        <= in_block[63:0];
            r_dec      <= decrypt;
            r_round    <= '0;
            r_tmr      <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_p_addr   <= kidx(decrypt, '0);
            r_state    <= S_KEY_XOR;
          end
        end
        S_KEY_XOR: begin
          r_l         <= r_l ^ p_data;
          r_ff_enable <= 1'b1;
          r_state     <= S_FF_RUN;
        end
        S_FF_RUN: begin
          if (ff_valid) begin
            r_fy        <= ff_y;
            r_ff_enable <= 1'b0;
            r_state     <= S_FF_DONE;
          end else if (r_tmr == TW'(FF_TIMEOUT - 1)) begin
            r_err       <= 1'b1;
            r_ff_enable <= 1'b0;
            r_tmr       <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_FF_DONE: begin
          r_l      <= r_r ^ r_fy;
          r_r      <= r_l;
          r_tmr    <= '0;
          r_round  <= w_round_nx;
          r_p_addr <= kidx(r_dec, w_round_nx);
          r_state  <= (r_round == RW'(NROUNDS - 1)) ? S_FIN_A : S_KEY_XOR;
        end
        S_FIN_A: begin
          // Undo the final swap and whiten R.
          r_l      <= r_r;
          r_r      <= r_l ^ p_data;
          r_round  <= w_round_nx;
          r_p_addr <= kidx(r_dec, w_round_nx);
          r_state  <= S_FIN_B;
        end
        S_FIN_B: begin
          r_l         <= r_l ^ p_data;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_block = {r_l, r_r};
  assign err       = r_err;
  assign p_addr    = r_p_addr;
  assign ff_enable = r_ff_enable;
  assign ff_x      = r_l;

endmodule

// File: tb/tb_blowfish128_round_ctrl.sv
// Bench for blowfish128_round_ctrl: stub F-function with programmable latency,
// P-array memory, and a plain Blowfish reference model.
module tb_blowfish128_round_ctrl;

  localparam int NR = 16;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         decrypt = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         err;
  logic [4:0]   p_addr;
  logic [63:0]  p_data;
  logic         ff_enable;
  logic [63:0]  ff_x;
  logic [63:0]  ff_y;
  logic         ff_valid;

  blowfish128_round_ctrl #(.NROUNDS(16), .FF_TIMEOUT(64)) dut (
    .Clk(Clk), .RstN(RstN),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .err(err),
    .p_addr(p_addr), .p_data(p_data),
    .ff_enable(ff_enable), .ff_x(ff_x), .ff_y(ff_y), .ff_valid(ff_valid)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // P-array store
  logic [63:0] p_mem [0:31];
  assign p_data = p_mem[p_addr];

  // Stub F-function
  int unsigned ff_lf = 6;
  bit ff_never = 1'b0;
  bit ff_noise = 1'b0;
  bit f_zero = 1'b0;
  int unsigned ff_cnt = 0;

  function automatic logic [63:0] ffn(input logic [63:0] x);
    logic [63:0] m;
    m = x * 64'h9E37_79B9_7F4A_7C15;
    return f_zero ? 64'd0 : (m ^ {x[31:0], x[63:32]} ^ (m >> 29));
  endfunction

  always @(posedge Clk) ff_cnt <= ff_enable ? ff_cnt + 1 : 0;
  assign ff_valid = ff_enable ? (!ff_never && ff_cnt == ff_lf - 1) : ff_noise;
  assign ff_y     = ff_enable ? ffn(ff_x) : 64'hA5A5_5A5A_F00D_BEEF;

  // Reference Blowfish (textbook form: xL ^= P; xR ^= F(xL); swap)
  function automatic logic [127:0] bf_model(input logic [127:0] blk, input bit dec);
    logic [63:0] xl, xr, t;
    xl = blk[127:64];
    xr = blk[63:0];
    for (int i = 0; i < NR; i++) begin
      xl = xl ^ p_mem[dec ? (NR + 1 - i) : i];
      xr = xr ^ ffn(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ p_mem[dec ? 1 : NR];
    xl = xl ^ p_mem[dec ? 0 : NR + 1];
    return {xl, xr};
  endfunction

  function automatic int lat_of(input int unsigned lf);
    return NR * (int'(lf) + 2) + 2;
  endfunction

  // Checking
  int n_chk = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: subkey index used each round, FIN indices, enable activity
  logic [4:0] pa_q[$];
  int  n_rise = 0;
  int  en_cycles = 0;
  bit  ov_seen = 1'b0;
  logic prev_en = 1'b0, prev_ov = 1'b0;
  logic [4:0] prev_pa = '0, prev2_pa = '0;
  always @(negedge Clk) begin
    if (ff_enable && !prev_en) begin
      pa_q.push_back(prev_pa);
      n_rise++;
    end
    if (out_valid && !prev_ov) begin
      pa_q.push_back(prev2_pa);
      pa_q.push_back(prev_pa);
      ov_seen = 1'b1;
    end
    if (ff_enable) en_cycles++;
    prev2_pa = prev_pa;
    prev_pa  = p_addr;
    prev_en  = ff_enable;
    prev_ov  = out_valid;
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  int acc = 0;

  task automatic accept(input logic [127:0] blk, input bit dec, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      check("in_ready_wait", 128'(in_ready), 128'(1));
      return;
    end
    in_block = blk;
    decrypt  = dec;
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    acc = cyc;
    pa_q.delete();
    n_rise = 0;
    en_cycles = 0;
    ov_seen = 1'b0;
    in_valid = 1'b0;
    decrypt  = 1'($urandom);
    in_block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_block(input logic [127:0] blk, input bit dec, input logic [127:0] exp,
                           input int lat_exp, input int hold, output logic [127:0] res);
    bit ok;
    bit seen;
    int held;
    res = '0;
    accept(blk, dec, ok);
    if (!ok) return;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check("out_valid_wait", 128'(out_valid), 128'(1));
      return;
    end
    res = out_block;
    check("out_block", out_block, exp);
    check("latency", 128'(cyc - acc), 128'(lat_exp));
    check("err_clear", 128'(err), 128'(0));
    check("round_count", 128'(n_rise), 128'(NR));
    check("paddr_len", 128'(pa_q.size()), 128'(NR + 2));
    for (int i = 0; i < NR + 2 && i < pa_q.size(); i++)
      check($sformatf("paddr[%0d]", i), 128'(pa_q[i]), 128'(dec ? NR + 1 - i : i));
    held = 0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      step();
      if (out_valid && out_block == res && !in_ready) held++;
    end
    in_valid = 1'b0;
    if (hold > 0) check("hold_stable", 128'(held), 128'(hold));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", 128'(out_valid), 128'(0));
    check("in_ready_back", 128'(in_ready), 128'(1));
  endtask

  task automatic rand_p();
    for (int k = 0; k < 32; k++) p_mem[k] = (k < NR + 2) ? {$urandom, $urandom} : 64'd0;
  endtask

  logic [127:0] vec, ct, pt, res;
  bit ok;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) p_mem[k] = 64'd0;
    RstN = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_ff_enable", 128'(ff_enable), 128'(0));
    check("rst_p_addr", 128'(p_addr), 128'(0));
    check("rst_out_block", out_block, 128'(0));
    RstN = 1'b1;
    step();

    // Zero P-array, F returns zero: only the half swap survives
    f_zero = 1'b1;
    ff_lf = 6;
    run_block(128'h0011223344556677_8899AABBCCDDEEFF, 1'b0,
              128'h8899AABBCCDDEEFF_0011223344556677, 130, 0, res);
    f_zero = 1'b0;

    // Random P-array, encrypt then decrypt round-trip
    rand_p();
    vec = 128'h0123456789ABCDEF_FEDCBA9876543210;
    ff_lf = $urandom_range(1, 8);
    run_block(vec, 1'b0, bf_model(vec, 1'b0), lat_of(ff_lf), 0, ct);
    ff_lf = $urandom_range(1, 8);
    run_block(ct, 1'b1, bf_model(ct, 1'b1), lat_of(ff_lf), 0, pt);
    check("roundtrip_fixed", pt, vec);

    for (int it = 0; it < 4; it++) begin
      rand_p();
      vec = {$urandom, $urandom, $urandom, $urandom};
      ff_lf = $urandom_range(1, 10);
      run_block(vec, 1'b0, bf_model(vec, 1'b0), lat_of(ff_lf), (it == 1) ? 20 : 0, ct);
      ff_lf = $urandom_range(1, 10);
      run_block(ct, 1'b1, bf_model(ct, 1'b1), lat_of(ff_lf), 0, pt);
      check("roundtrip_rand", pt, vec);
    end

    // F-function never answers: abort with sticky err
    ff_never = 1'b1;
    accept({$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
    for (int k = 0; k < 3000 && !in_ready; k++) step();
    check("to_in_ready", 128'(in_ready), 128'(1));
    check("to_err", 128'(err), 128'(1));
    check("to_ff_cycles", 128'(en_cycles), 128'(64));
    check("to_ff_enable", 128'(ff_enable), 128'(0));
    repeat (5) step();
    check("to_err_sticky", 128'(err), 128'(1));
    check("to_no_output", 128'(ov_seen), 128'(0));
    ff_never = 1'b0;
    vec = {$urandom, $urandom, $urandom, $urandom};
    ff_lf = 3;
    run_block(vec, 1'b0, bf_model(vec, 1'b0), lat_of(3), 0, ct);

    // Reset pulse during round 7 F-function wait
    ff_lf = 6;
    accept({$urandom, $urandom, $urandom, $urandom}, 1'b1, ok);
    for (int k = 0; k < 2000 && n_rise < 8; k++) step();
    step();
    step();
    #1 RstN = 1'b0;
    #1;
    check("mid_rst_ff_enable", 128'(ff_enable), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_p_addr", 128'(p_addr), 128'(0));
    step();
    step();
    RstN = 1'b1;
    step();
    vec = {$urandom, $urandom, $urandom, $urandom};
    run_block(vec, 1'b0, bf_model(vec, 1'b0), lat_of(6), 0, ct);

    // Spurious ff_valid whenever ff_enable is low
    ff_noise = 1'b1;
    for (int it = 0; it < 2; it++) begin
      rand_p();
      vec = {$urandom, $urandom, $urandom, $urandom};
      ff_lf = $urandom_range(1, 6);
      run_block(vec, 1'(it), bf_model(vec, 1'(it)), lat_of(ff_lf), 0, ct);
    end
    ff_noise = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
